// File: rtl/fe_fb_pkg.sv
// Shared fetch-buffer types: front-end request/response structs, line geometry and fill FSM states.
package fe_fb_pkg;

  localparam int unsigned FB_PA_W        = 32;
  localparam int unsigned FB_ID_W        = 4;
  localparam int unsigned FB_LINE_BYTES  = 32;
  localparam int unsigned FB_NUM_ENTRIES = 4;
  localparam int unsigned FB_OFF_W       = $clog2(FB_LINE_BYTES);

  typedef logic [FB_PA_W-1:0] t_paddr;
  typedef logic [FB_PA_W-FB_OFF_W-1:0] t_fb_line_addr;

  typedef struct packed {
    logic               valid;
    t_paddr             addr;
    logic [FB_ID_W-1:0] id;
  } t_fe_fb_req;

  typedef struct packed {
    logic               valid;
    logic [31:0]        instr;
    t_paddr             pc;
    logic [FB_ID_W-1:0] id;
  } t_fb_fe_rsp;

  typedef enum logic [1:0] {
    FB_IDLE,
    FB_FILL_REQ,
    FB_FILL_WAIT,
    FB_FILL_DROP
  } t_fsm_fb;

endpackage

// File: rtl/fe_fb_entry.sv
// One fetch-buffer line: tag, valid bit, line data, fill write port, tag compare and word select.
module fe_fb_entry #(
  parameter int unsigned LINE_BYTES = 32,
  parameter int unsigned TAG_W      = 27,
  parameter int unsigned WSEL_W     = $clog2(LINE_BYTES) - 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [TAG_W-1:0]        wr_tag,
  input  logic [LINE_BYTES*8-1:0] wr_data,
  input  logic [TAG_W-1:0]        lookup_tag,
  input  logic [WSEL_W-1:0]       word_sel,
  output logic                    hit,
  output logic [31:0]             word
);

  localparam int unsigned NumWords = LINE_BYTES / 4;

  logic                          valid_q;
  logic [TAG_W-1:0]              tag_q;
  logic [NumWords-1:0][31:0]     words_q;

  // Flush wins over a concurrent fill; the top also gates wr_en with flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (wr_en) begin
      valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q   <= wr_tag;
      words_q <= wr_data;
    end
  end

  assign hit  = valid_q && (tag_q == lookup_tag);
  assign word = words_q[word_sel];

endmodule

// File: rtl/fe_fb.sv
// Fetch buffer: fully-associative line store answering front-end fetches, with a single-fill
// miss engine. Define FB_STATS_EN to add saturating hit/miss/fill/drop counters.
module fe_fb
  import fe_fb_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = FB_NUM_ENTRIES,
  parameter int unsigned LINE_BYTES  = FB_LINE_BYTES,
  parameter int unsigned PA_W        = FB_PA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  t_fe_fb_req              fe_fb_req_fb0,
  output t_fb_fe_rsp              fb_fe_rsp_fb0,
  input  logic                    flush_fb,
  output logic                    fb_mem_req_valid,
  output logic [PA_W-1:0]         fb_mem_req_addr,
  input  logic                    mem_fb_req_ready,
  input  logic                    mem_fb_rsp_valid,
  input  logic [LINE_BYTES*8-1:0] mem_fb_rsp_data
);

  localparam int unsigned OffW  = $clog2(LINE_BYTES);
  localparam int unsigned TagW  = PA_W - OffW;
  localparam int unsigned WselW = OffW - 2;
  localparam int unsigned IdxW  = $clog2(NUM_ENTRIES);

  t_fsm_fb               state_q;
  logic [IdxW-1:0]       rr_ptr_q;
  logic [TagW-1:0]       fill_tag_q;
  logic                  req_valid_q;
  t_fb_fe_rsp            rsp_q;

  logic [TagW-1:0]       req_tag;
  logic [WselW-1:0]      word_sel;
  logic [NUM_ENTRIES-1:0] hits;
  logic [31:0]           words [NUM_ENTRIES];
  logic [31:0]           hit_word;
  logic                  raw_hit;
  logic                  lookup_hit;
  logic                  lookup_miss;
  logic                  fill_wr;

  assign req_tag  = fe_fb_req_fb0.addr[PA_W-1:OffW];
  assign word_sel = fe_fb_req_fb0.addr[OffW-1:2];

  // A fill arriving together with a flush is discarded.
  assign fill_wr = (state_q == FB_FILL_WAIT) && mem_fb_rsp_valid && !flush_fb;

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
    fe_fb_entry #(
      .LINE_BYTES (LINE_BYTES),
      .TAG_W      (TagW),
      .WSEL_W     (WselW)
    ) u_entry (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush_fb),
      .wr_en      (fill_wr && (rr_ptr_q == IdxW'(i))),
      .wr_tag     (fill_tag_q),
      .wr_data    (mem_fb_rsp_data),
      .lookup_tag (req_tag),
      .word_sel   (word_sel),
      .hit        (hits[i]),
      .word       (words[i])
    );
  end

  always_comb begin
    hit_word = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (hits[i]) hit_word = hit_word | words[i];
    end
  end

  assign raw_hit     = |hits;
  assign lookup_hit  = fe_fb_req_fb0.valid && raw_hit && !flush_fb;
  assign lookup_miss = fe_fb_req_fb0.valid && !raw_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_q <= '0;
    end else if (lookup_hit) begin
      rsp_q.valid <= 1'b1;
      rsp_q.instr <= hit_word;
      rsp_q.pc    <= fe_fb_req_fb0.addr;
      rsp_q.id    <= fe_fb_req_fb0.id;
    end else begin
      rsp_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FB_IDLE;
      rr_ptr_q    <= '0;
      fill_tag_q  <= '0;
      req_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        FB_IDLE: begin
          if (lookup_miss && !flush_fb) begin
            state_q     <= FB_FILL_REQ;
            fill_tag_q  <= req_tag;
            req_valid_q <= 1'b1;
          end
        end
        FB_FILL_REQ: begin
          if (mem_fb_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= flush_fb ? FB_FILL_DROP : FB_FILL_WAIT;
          end else if (flush_fb) begin
            req_valid_q <= 1'b0;
            state_q     <= FB_IDLE;
          end
        end
        FB_FILL_WAIT: begin
          if (mem_fb_rsp_valid) begin
            state_q <= FB_IDLE;
            if (!flush_fb) rr_ptr_q <= rr_ptr_q + IdxW'(1);
          end else if (flush_fb) begin
            state_q <= FB_FILL_DROP;
          end
        end
        FB_FILL_DROP: begin
          if (mem_fb_rsp_valid) state_q <= FB_IDLE;
        end
        default: state_q <= FB_IDLE;
      endcase
    end
  end

  assign fb_fe_rsp_fb0    = rsp_q;
  assign fb_mem_req_valid = req_valid_q;
  assign fb_mem_req_addr  = {fill_tag_q, {OffW{1'b0}}};

  a_single_hit : assert property (@(posedge clk) disable iff (!reset) $onehot0(hits));

  // A stray fill beat (e.g. one left over from before a reset) is harmless, so only warn.
  a_rsp_expected : assert property (@(posedge clk) disable iff (!reset)
      mem_fb_rsp_valid |-> (state_q == FB_FILL_WAIT || state_q == FB_FILL_DROP))
    else $warning("fe_fb: fill beat with no fill outstanding ignored");

`ifdef FB_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, fill_cnt_q, drop_cnt_q, req_cnt_q;

  function automatic logic [31:0] sat_inc(logic [31:0] v, logic en);
    return (en && v != '1) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      fill_cnt_q <= '0;
      drop_cnt_q <= '0;
      req_cnt_q  <= '0;
    end else begin
      hit_cnt_q  <= sat_inc(hit_cnt_q, lookup_hit);
      miss_cnt_q <= sat_inc(miss_cnt_q, fe_fb_req_fb0.valid && !lookup_hit);
      fill_cnt_q <= sat_inc(fill_cnt_q, fill_wr);
      drop_cnt_q <= sat_inc(drop_cnt_q, (state_q == FB_FILL_DROP) && mem_fb_rsp_valid);
      req_cnt_q  <= sat_inc(req_cnt_q, fe_fb_req_fb0.valid);
    end
  end

  a_stats_sum : assert property (@(posedge clk) disable iff (!reset || req_cnt_q == '1)
      {1'b0, hit_cnt_q} + {1'b0, miss_cnt_q} == {1'b0, req_cnt_q});

  final begin
    $display("fe_fb stats: hit=%0d miss=%0d fill=%0d flush_drop=%0d",
             hit_cnt_q, miss_cnt_q, fill_cnt_q, drop_cnt_q);
  end
`else
`endif

endmodule
